// File: rtl/rx_iq_fifo_pkg.sv
// -----------------------------------------------------------------------------
// rx_iq_fifo_pkg
// Shared definitions for the receive IQ frame FIFO:
//   IQ_W       - width of one signed I or Q sample
//   DEPTH_DEF  - default number of frames held by the FIFO
//   OVF_W      - width of the saturating dropped-frame counter
//   iq_frame_t - one IQ frame (RX1 I/Q followed by RX2 I/Q, MSB first)
//   ovf_next() - next value of the dropped-frame counter
// -----------------------------------------------------------------------------
package rx_iq_fifo_pkg;

  localparam int IQ_W      = 32;
  localparam int DEPTH_DEF = 8;
  localparam int OVF_W     = 16;

  typedef struct packed {
    logic signed [IQ_W-1:0] rx1_i;
    logic signed [IQ_W-1:0] rx1_q;
    logic signed [IQ_W-1:0] rx2_i;
    logic signed [IQ_W-1:0] rx2_q;
  } iq_frame_t;

  // Clear wins over increment; the count sticks at all-ones.
  function automatic logic [OVF_W-1:0] ovf_next(
    input logic [OVF_W-1:0] cnt,
    input logic             clr,
    input logic             inc
  );
    logic [OVF_W-1:0] res;
    if (clr) begin
      res = {OVF_W{1'b0}};
    end else if (inc && (cnt != {OVF_W{1'b1}})) begin
      res = cnt + {{(OVF_W-1){1'b0}}, 1'b1};
    end else begin
      res = cnt;
    end
    return res;
  endfunction

endpackage : rx_iq_fifo_pkg

// File: rtl/rx_iq_fifo_ram.sv
// -----------------------------------------------------------------------------
// rx_iq_fifo_ram
// Simple dual-port frame memory: synchronous write port, registered read port.
// A read and a write to the same address in one cycle return the old contents
// (read-before-write), which the FIFO relies on when it is full.
// Storage is never reset; only the read data register is.
//
// Ports:
//   clk_i    - clock
//   reset_i  - synchronous active-high reset of the read register
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   re_i     - read enable (read register updates only when set)
//   raddr_i  - read address
//   rdata_o  - registered read data (holds when re_i is low)
// -----------------------------------------------------------------------------
module rx_iq_fifo_ram #(
  parameter  int DEPTH  = 8,
  parameter  int DATA_W = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port: storage contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: registered output, cleared by reset, held when not reading.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdata_q <= {DATA_W{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : rx_iq_fifo_ram

// File: rtl/rx_iq_fifo.sv
// -----------------------------------------------------------------------------
// rx_iq_fifo
// Frame FIFO between the DDC stage and the bus interface. Each entry holds one
// IQ frame. When full, a write without a pop drops the oldest frame and counts
// it in overflow_cnt. Pointers are plain log2(DEPTH)-bit indices; occupancy is
// tracked by a separate level counter.
//
// Build option:
//   RX_IQ_FIFO_RX2_EN - when defined, RX2 samples are stored and returned;
//                       otherwise no RX2 storage exists, RX2 inputs are ignored
//                       and out_rx2_* read as zero.
//
// Ports:
//   clk_in        - single clock
//   reset         - synchronous active-high reset, highest priority
//   iq_valid      - write strobe, one frame per asserted cycle
//   RX1_I..RX2_Q  - input samples (signed)
//   flush         - empty the FIFO (beats write and pop)
//   pop           - read request; frame appears on out_* one cycle later
//   out_rx1_i..   - registered read frame
//   out_valid     - one-cycle pulse with each new read frame
//   empty, full   - registered status flags
//   level         - frames stored, 0..DEPTH
//   overflow_cnt  - saturating count of dropped frames
//   overflow_clr  - clear overflow_cnt (beats an increment)
// -----------------------------------------------------------------------------
module rx_iq_fifo
  import rx_iq_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   iq_valid,
  input  logic signed [IQ_W-1:0] RX1_I,
  input  logic signed [IQ_W-1:0] RX1_Q,
  input  logic signed [IQ_W-1:0] RX2_I,
  input  logic signed [IQ_W-1:0] RX2_Q,
  input  logic                   flush,
  input  logic                   pop,
  output logic signed [IQ_W-1:0] out_rx1_i,
  output logic signed [IQ_W-1:0] out_rx1_q,
  output logic signed [IQ_W-1:0] out_rx2_i,
  output logic signed [IQ_W-1:0] out_rx2_q,
  output logic                   out_valid,
  output logic                   empty,
  output logic                   full,
  output logic [LVL_W-1:0]       level,
  output logic [OVF_W-1:0]       overflow_cnt,
  input  logic                   overflow_clr
);

  localparam int PTR_W = $clog2(DEPTH);
`ifdef RX_IQ_FIFO_RX2_EN
  localparam int FRAME_W = 4 * IQ_W;
`else
  localparam int FRAME_W = 2 * IQ_W;
`endif

  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               empty_q, empty_d;
  logic               full_q, full_d;
  logic               out_valid_q, out_valid_d;
  logic [OVF_W-1:0]   ovf_q, ovf_d;

  logic               wr_s;
  logic               rd_s;
  logic               drop_s;
  logic               ram_we_s;
  logic               ram_re_s;
  logic [FRAME_W-1:0] wdata_s;
  logic [FRAME_W-1:0] rdata_s;
  iq_frame_t          rd_frame_s;

  // Pack the incoming frame and unpack the memory output.
`ifdef RX_IQ_FIFO_RX2_EN
  assign wdata_s    = {RX1_I, RX1_Q, RX2_I, RX2_Q};
  assign rd_frame_s = rdata_s;
`else
  logic unused_rx2_s;
  assign unused_rx2_s = ^{RX2_I, RX2_Q};
  assign wdata_s      = {RX1_I, RX1_Q};
  assign rd_frame_s   = {rdata_s, {(2*IQ_W){1'b0}}};
`endif

  // Next-state pointers, level, flags, read pulse and overflow counter.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    wr_s    = 1'b0;
    rd_s    = 1'b0;
    drop_s  = 1'b0;
    if (flush) begin
      head_d  = {PTR_W{1'b0}};
      tail_d  = {PTR_W{1'b0}};
      level_d = {LVL_W{1'b0}};
    end else begin
      wr_s = iq_valid;
      // A pop on an empty FIFO is ignored even if a write arrives alongside.
      rd_s = pop && !empty_q;
      case ({wr_s, rd_s})
        2'b11: begin
          head_d = head_q + {{(PTR_W-1){1'b0}}, 1'b1};
          tail_d = tail_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end
        2'b10: begin
          head_d = head_q + {{(PTR_W-1){1'b0}}, 1'b1};
          if (full_q) begin
            // Overwrite the oldest frame: tail follows head, level stays.
            tail_d = tail_q + {{(PTR_W-1){1'b0}}, 1'b1};
            drop_s = 1'b1;
          end else begin
            level_d = level_q + {{(LVL_W-1){1'b0}}, 1'b1};
          end
        end
        2'b01: begin
          tail_d  = tail_q + {{(PTR_W-1){1'b0}}, 1'b1};
          level_d = level_q - {{(LVL_W-1){1'b0}}, 1'b1};
        end
        default: begin
          head_d = head_q;
        end
      endcase
    end
    out_valid_d = rd_s;
    empty_d     = (level_d == {LVL_W{1'b0}});
    full_d      = (level_d == LVL_W'(DEPTH));
    ovf_d       = ovf_next(ovf_q, overflow_clr, drop_s);
  end

  // Reset overrides every memory access so no read completes after it.
  assign ram_we_s = wr_s && !reset;
  assign ram_re_s = rd_s && !reset;

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      head_q      <= {PTR_W{1'b0}};
      tail_q      <= {PTR_W{1'b0}};
      level_q     <= {LVL_W{1'b0}};
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      out_valid_q <= 1'b0;
      ovf_q       <= {OVF_W{1'b0}};
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      level_q     <= level_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  rx_iq_fifo_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (FRAME_W)
  ) u_ram (
    .clk_i   (clk_in),
    .reset_i (reset),
    .we_i    (ram_we_s),
    .waddr_i (head_q),
    .wdata_i (wdata_s),
    .re_i    (ram_re_s),
    .raddr_i (tail_q),
    .rdata_o (rdata_s)
  );

  assign out_rx1_i    = rd_frame_s.rx1_i;
  assign out_rx1_q    = rd_frame_s.rx1_q;
  assign out_rx2_i    = rd_frame_s.rx2_i;
  assign out_rx2_q    = rd_frame_s.rx2_q;
  assign out_valid    = out_valid_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign level        = level_q;
  assign overflow_cnt = ovf_q;

endmodule : rx_iq_fifo

// File: doc/rx_iq_fifo.md
RX_IQ_FIFO -- requirements
Module: rx_iq_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of IQ frames stored; power of two, 4..64.
REQ-002 SHALL have parameter LVL_W, default $clog2(DEPTH)+1, width of the level output.
REQ-003 SHALL have port clk_in, input, 1, single clock for all logic.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port iq_valid, input, 1, one-cycle write strobe from the DDC stage, already synchronous to clk_in.
REQ-006 SHALL have ports RX1_I, RX1_Q, RX2_I and RX2_Q, input, signed 32 each, DDC output samples.
REQ-007 SHALL have port flush, input, 1, synchronous empty request from the bus interface.
REQ-008 SHALL have port pop, input, 1, one-cycle read request from the bus interface.
REQ-009 SHALL have ports out_rx1_i, out_rx1_q, out_rx2_i and out_rx2_q, output, signed 32 each, registered read frame.
REQ-010 SHALL have port out_valid, output, 1, one-cycle pulse marking a new read frame.
REQ-011 SHALL have ports empty and full, output, 1 each, registered status flags.
REQ-012 SHALL have port level, output, LVL_W, number of frames stored, 0..DEPTH.
REQ-013 SHALL have port overflow_cnt, output, 16, saturating count of dropped frames.
REQ-014 SHALL have port overflow_clr, input, 1, clears overflow_cnt.

Function
REQ-015 Write: iq_valid=1 SHALL store all four samples at head in the same cycle, then advance head modulo DEPTH.
REQ-016 Read: pop=1 with empty=0 in cycle N SHALL drive the tail frame on out_* and pulse out_valid in cycle N+1, then advance tail modulo DEPTH.
REQ-017 Pop with empty=1 SHALL be ignored: out_valid stays 0, out_* hold their values, pointers do not change.
REQ-018 Full plus write without pop SHALL drop the oldest frame: overwrite it, advance head and tail, keep level=DEPTH, increment overflow_cnt.
REQ-019 Full plus write plus pop SHALL return the oldest frame, store the new one and leave level=DEPTH, with no overflow counted.
REQ-020 Empty plus write plus pop SHALL ignore the pop and store the write, giving level=1 with no bypass.
REQ-021 Otherwise simultaneous write and pop SHALL both occur with level unchanged.
REQ-022 overflow_cnt SHALL saturate at 16'hFFFF; overflow_clr SHALL take priority over an increment in the same cycle.
REQ-023 flush SHALL set head=tail=0, level=0 and empty=1 next cycle, take priority over a write or pop in the same cycle, and leave overflow_cnt unchanged.
REQ-024 Flags SHALL satisfy empty=(level==0) and full=(level==DEPTH), registered alongside level.
REQ-025 Pointers SHALL be log2(DEPTH) bits plus a separate level counter; there is no wrap-bit comparison.

Reset
REQ-026 reset SHALL set head=0, tail=0, level=0, empty=1, full=0, out_valid=0, out_*=0 and overflow_cnt=0; storage contents are not reset.
REQ-027 reset SHALL take priority over every other input, including mid-read: no out_valid pulse follows a pop issued in the reset cycle.

Configuration
REQ-028 With RX_IQ_FIFO_RX2_EN defined, the block SHALL store and output RX2 samples.
REQ-029 Without RX_IQ_FIFO_RX2_EN, the block SHALL allocate no RX2 storage, tie out_rx2_i and out_rx2_q to 0, ignore RX2_I and RX2_Q, and keep the port list unchanged.

Structure
REQ-030 A shared package SHALL hold the IQ sample width constant (32), the iq_frame_t struct (rx1_i, rx1_q, rx2_i, rx2_q), the default DEPTH and the overflow counter width.
REQ-031 The block SHALL contain one sub-module, rx_iq_fifo_ram: a simple dual-port memory with synchronous write and registered read.

Verification
REQ-032 After reset, write frames 1..3 (RX1_I=1,2,3), then issue three pops: out_valid pulses 1 cycle after each pop, RX1_I reads 1,2,3, and empty=1 at the end.
REQ-033 Write 10 frames (RX1_I=0..9) into DEPTH=8 with no pop, then drain: overflow_cnt=2, reads return 2..9, and full=1 before the drain.
REQ-034 At full, apply iq_valid and pop in the same cycle: oldest frame is returned, level stays 8, overflow_cnt is unchanged.
REQ-035 Pop while empty, and pop with write into an empty FIFO: no out_valid, then level=1.
REQ-036 Apply flush together with iq_valid at level=5: level=0, empty=1, and the written frame is discarded.
REQ-037 Build without RX_IQ_FIFO_RX2_EN, drive RX2_I=32'h1234 and pop: out_rx2_i=0 while RX1 data is correct.
